// File: rtl/acc_bias_unit_pkg.sv
// Shared accelerator definitions: default widths and the accumulate/bias FSM encoding.
package acc_bias_unit_pkg;

    localparam int DEF_D_BW   = 8;
    localparam int DEF_PS_BW  = 17;
    localparam int DEF_AB_BW  = 21;
    localparam int DEF_LEN_BW = 4;

    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/acc_bias_unit_if.sv
// Job/beat/result bundle between the partial-sum producer and the accumulate-plus-bias unit.
interface acc_bias_unit_if
    import acc_bias_unit_pkg::*;
#(
    parameter int D_BW   = DEF_D_BW,
    parameter int PS_BW  = DEF_PS_BW,
    parameter int AB_BW  = DEF_AB_BW,
    parameter int LEN_BW = DEF_LEN_BW
);
    logic                     i_start;
    logic        [LEN_BW-1:0] i_acc_len;
    logic signed [D_BW-1:0]   i_bias0;
    logic signed [D_BW-1:0]   i_bias1;
    logic signed [D_BW-1:0]   i_bias2;
    logic                     i_psum_valid;
    logic signed [PS_BW-1:0]  i_psum0;
    logic signed [PS_BW-1:0]  i_psum1;
    logic signed [PS_BW-1:0]  i_psum2;
    logic                     o_busy;
    logic                     o_acc_valid;
    logic signed [AB_BW-1:0]  o_acc_bias0;
    logic signed [AB_BW-1:0]  o_acc_bias1;
    logic signed [AB_BW-1:0]  o_acc_bias2;

    modport master (
        output i_start, i_acc_len, i_bias0, i_bias1, i_bias2,
        output i_psum_valid, i_psum0, i_psum1, i_psum2,
        input  o_busy, o_acc_valid, o_acc_bias0, o_acc_bias1, o_acc_bias2
    );

    modport slave (
        input  i_start, i_acc_len, i_bias0, i_bias1, i_bias2,
        input  i_psum_valid, i_psum0, i_psum1, i_psum2,
        output o_busy, o_acc_valid, o_acc_bias0, o_acc_bias1, o_acc_bias2
    );

endinterface

// File: rtl/acc_bias_lane.sv
// One channel: latched bias, wide accumulator, saturating bias add into a result register.
module acc_bias_lane #(
    parameter int D_BW  = 8,
    parameter int PS_BW = 17,
    parameter int AB_BW = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic                    bias_en,
    input  logic signed [D_BW-1:0]  bias_in,
    input  logic signed [PS_BW-1:0] psum,
    output logic signed [AB_BW-1:0] result
);
    localparam logic [AB_BW-1:0] SAT_MAX = {1'b0, {(AB_BW-1){1'b1}}};
    localparam logic [AB_BW-1:0] SAT_MIN = {1'b1, {(AB_BW-1){1'b0}}};

    logic signed [D_BW-1:0]  bias_q;
    logic signed [AB_BW-1:0] acc_q;
    logic        [AB_BW-1:0] psum_ext;
    logic        [AB_BW:0]   sum;
    logic        [AB_BW-1:0] sat;

    assign psum_ext = {{(AB_BW-PS_BW){psum[PS_BW-1]}}, psum};

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sum = {acc_q[AB_BW-1], acc_q} + {{(AB_BW+1-D_BW){bias_q[D_BW-1]}}, bias_q};

    always_comb begin
        sat = sum[AB_BW-1:0];
        if (sum[AB_BW] != sum[AB_BW-1]) begin
            sat = sum[AB_BW] ? SAT_MIN : SAT_MAX;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q <= '0;
            acc_q  <= '0;
            result <= '0;
        end else begin
            if (load) begin
                bias_q <= bias_in;
                acc_q  <= '0;
            end else if (acc_en) begin
                acc_q <= acc_q + psum_ext;
            end
            if (bias_en) begin
                result <= sat;
            end
        end
    end

endmodule

// File: rtl/acc_bias_unit.sv
// Three-channel accumulate-then-bias unit: FSM and beat counter drive three identical lanes.
module acc_bias_unit
    import acc_bias_unit_pkg::*;
#(
    parameter int D_BW   = DEF_D_BW,
    parameter int PS_BW  = DEF_PS_BW,
    parameter int AB_BW  = DEF_AB_BW,
    parameter int LEN_BW = DEF_LEN_BW
) (
    input logic            clk,
    input logic            rst,
    acc_bias_unit_if.slave bus
);
    state_t              state, next_state;
    logic [LEN_BW-1:0]   len_q;
    logic [LEN_BW-1:0]   cnt_q;
    logic                start_ok;
    logic                beat;
    logic                last_beat;

    logic signed [D_BW-1:0]  bias   [NUM_LANES];
    logic signed [PS_BW-1:0] psum   [NUM_LANES];
    logic signed [AB_BW-1:0] result [NUM_LANES];

    assign start_ok  = (state == ST_IDLE) && bus.i_start;
    assign beat      = (state == ST_ACC) && bus.i_psum_valid;
    assign last_beat = beat && (cnt_q == len_q);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_ok)  next_state = ST_ACC;
            ST_ACC:  if (last_beat) next_state = ST_BIAS;
            ST_BIAS: next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                len_q <= bus.i_acc_len;
                cnt_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bias[0] = bus.i_bias0;
    assign bias[1] = bus.i_bias1;
    assign bias[2] = bus.i_bias2;
    assign psum[0] = bus.i_psum0;
    assign psum[1] = bus.i_psum1;
    assign psum[2] = bus.i_psum2;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        acc_bias_lane #(
            .D_BW  (D_BW),
            .PS_BW (PS_BW),
            .AB_BW (AB_BW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (start_ok),
            .acc_en  (beat),
            .bias_en (state == ST_BIAS),
            .bias_in (bias[g]),
            .psum    (psum[g]),
            .result  (result[g])
        );
    end

    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_acc_valid = (state == ST_DONE);
    assign bus.o_acc_bias0 = result[0];
    assign bus.o_acc_bias1 = result[1];
    assign bus.o_acc_bias2 = result[2];

endmodule

// File: tb/tb_acc_bias_unit.sv
// Directed bench for acc_bias_unit: basic job, single beat, saturation, gaps, mid-job reset.
module tb_acc_bias_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    acc_bias_unit_if bus ();

    acc_bias_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic signed [20:0] res [3];
    assign res[0] = bus.o_acc_bias0;
    assign res[1] = bus.o_acc_bias1;
    assign res[2] = bus.o_acc_bias2;

    // Advance one edge and settle just after it; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit v, input int p0, input int p1, input int p2);
        bus.i_psum_valid = v;
        bus.i_psum0 = 17'(p0);
        bus.i_psum1 = 17'(p1);
        bus.i_psum2 = 17'(p2);
    endtask

    task automatic start_job(input int len, input int b0, input int b1, input int b2);
        bus.i_start   = 1'b1;
        bus.i_acc_len = 4'(len);
        bus.i_bias0   = 8'(b0);
        bus.i_bias1   = 8'(b1);
        bus.i_bias2   = 8'(b2);
        step();
        bus.i_start = 1'b0;
    endtask

    // Steps until o_acc_valid is seen or the budget runs out; found reports which.
    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.o_acc_valid === 1'b1) found = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_psum_valid = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %0b want 0", bus.o_busy);
        end
        n_cmp++;
        if (bus.o_acc_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b want 0", bus.o_acc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== 21'sd0) begin
                n_err++; $display("FAIL reset_result%0d: got %0d want 0", i, res[i]);
            end
        end
        bus.i_start = 1'b0;
        bus.i_psum_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic signed [20:0] exp_v [3] = '{21'sd41, -21'sd21, 21'sd400};
        start_job(3, 1, -1, 0);
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin
            n_err++; $display("FAIL basic_busy: got %0b want 1", bus.o_busy);
        end
        for (int b = 0; b < 4; b++) begin
            drive_beat(1'b1, 10, -5, 100);
            step();
        end
        drive_beat(1'b0, 0, 0, 0);
        n_cmp++;
        if (bus.o_acc_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_latency_early: got %0b want 0 one cycle after last beat", bus.o_acc_valid);
        end
        step();
        n_cmp++;
        if (bus.o_acc_valid !== 1'b1) begin
            n_err++; $display("FAIL basic_latency: got %0b want 1 two cycles after last beat", bus.o_acc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== exp_v[i]) begin
                n_err++; $display("FAIL basic_result%0d: got %0d want %0d", i, res[i], exp_v[i]);
            end
        end
        step();
        n_cmp++;
        if (bus.o_acc_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++; $display("FAIL basic_pulse_end: got valid=%0b busy=%0b want 0/0", bus.o_acc_valid, bus.o_busy);
        end
        n_cmp++;
        if (res[0] !== 21'sd41) begin
            n_err++; $display("FAIL basic_hold: got %0d want 41", res[0]);
        end
    endtask

    task automatic test_single_beat();
        int  busy_cycles = 0;
        bit  seen_valid;
        logic signed [20:0] r0;
        start_job(0, -128, 0, 0);
        drive_beat(1'b1, -7, 0, 0);
        if (bus.o_busy === 1'b1) busy_cycles++;
        step();
        drive_beat(1'b0, 0, 0, 0);
        if (bus.o_busy === 1'b1) busy_cycles++;
        step();
        if (bus.o_busy === 1'b1) busy_cycles++;
        seen_valid = (bus.o_acc_valid === 1'b1);
        r0 = res[0];
        step();
        if (bus.o_busy === 1'b1) busy_cycles++;
        n_cmp++;
        if (busy_cycles != 3) begin
            n_err++; $display("FAIL single_busy_cycles: got %0d want 3", busy_cycles);
        end
        n_cmp++;
        if (!seen_valid) begin
            n_err++; $display("FAIL single_valid: got 0 want 1 in third busy cycle");
        end
        n_cmp++;
        if (r0 !== -21'sd135) begin
            n_err++; $display("FAIL single_result0: got %0d want -135", r0);
        end
    endtask

    task automatic test_saturation();
        bit found;
        logic signed [20:0] exp_v [3] = '{21'sd1048575, -21'sd1048576, 21'sd0};
        start_job(15, 127, -1, 0);
        for (int b = 0; b < 16; b++) begin
            drive_beat(1'b1, 65535, -65536, 0);
            step();
        end
        drive_beat(1'b0, 0, 0, 0);
        wait_valid(8, found);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL sat_timeout: got no o_acc_valid want pulse within 8 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== exp_v[i]) begin
                n_err++; $display("FAIL sat_result%0d: got %0d want %0d", i, res[i], exp_v[i]);
            end
        end
        step();
    endtask

    task automatic test_gaps();
        bit pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        bit found;
        logic signed [20:0] exp_v [3] = '{21'sd8, 21'sd57, 21'sd600};
        start_job(2, 2, -3, 0);
        for (int i = 0; i < 6; i++) begin
            if (pattern[i]) begin
                k++;
                drive_beat(1'b1, k, 10 * k, 100 * k);
            end else begin
                drive_beat(1'b0, 999, 999, 999);
            end
            if (i == 2) begin
                bus.i_start   = 1'b1;
                bus.i_acc_len = 4'd0;
                bus.i_bias0   = 8'sd50;
                bus.i_bias1   = 8'sd50;
                bus.i_bias2   = 8'sd50;
            end
            step();
            bus.i_start = 1'b0;
        end
        // Keep valid high with junk after the last beat: it must not reach the accumulators.
        drive_beat(1'b1, 7, 7, 7);
        wait_valid(8, found);
        drive_beat(1'b0, 0, 0, 0);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL gaps_timeout: got no o_acc_valid want pulse within 8 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== exp_v[i]) begin
                n_err++; $display("FAIL gaps_result%0d: got %0d want %0d", i, res[i], exp_v[i]);
            end
        end
        step();
        step();
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++; $display("FAIL gaps_no_restart: got busy=%0b want 0", bus.o_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit stray = 1'b0;
        logic signed [20:0] exp_v [3] = '{21'sd11, 21'sd13, 21'sd15};
        start_job(3, 0, 0, 0);
        for (int b = 0; b < 2; b++) begin
            drive_beat(1'b1, 5, 6, 7);
            step();
        end
        drive_beat(1'b0, 0, 0, 0);
        rst = 1'b1;
        step();
        if (bus.o_acc_valid === 1'b1) stray = 1'b1;
        rst = 1'b0;
        n_cmp++;
        if (bus.o_busy !== 1'b0 || stray) begin
            n_err++; $display("FAIL midrst_state: got busy=%0b valid=%0b want 0/0", bus.o_busy, stray);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== 21'sd0) begin
                n_err++; $display("FAIL midrst_result%0d: got %0d want 0", i, res[i]);
            end
        end
        start_job(1, 1, 1, 1);
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin
            n_err++; $display("FAIL midrst_restart: got busy=%0b want 1", bus.o_busy);
        end
        for (int b = 0; b < 2; b++) begin
            drive_beat(1'b1, 5, 6, 7);
            step();
        end
        drive_beat(1'b0, 0, 0, 0);
        wait_valid(8, found);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL midrst_timeout: got no o_acc_valid want pulse within 8 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== exp_v[i]) begin
                n_err++; $display("FAIL midrst_result_new%0d: got %0d want %0d", i, res[i], exp_v[i]);
            end
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_acc_len = '0;
        bus.i_bias0 = '0;
        bus.i_bias1 = '0;
        bus.i_bias2 = '0;
        drive_beat(1'b0, 0, 0, 0);
        test_reset();
        test_basic();
        test_single_beat();
        test_saturation();
        test_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_bias_unit.md
ACC_BIAS_UNIT -- requirements
Module: acc_bias_unit

Interface
REQ-001 SHALL have parameter D_BW, default 8, bias width (signed).
REQ-002 SHALL have parameter PS_BW, default 17, per-channel partial-sum width (signed).
REQ-003 SHALL have parameter AB_BW, default 21, accumulated-plus-bias output width (signed).
REQ-004 SHALL have parameter LEN_BW, default 4, accumulation-length field width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_start  input  1  begin one accumulation job; sampled only in IDLE.
REQ-008 SHALL have port i_acc_len  input  LEN_BW  beat count minus one (0 -> 1 beat, 15 -> 16 beats), latched on accepted i_start.
REQ-009 SHALL have ports i_bias0/1/2  input  D_BW each  per-channel signed bias, latched on accepted i_start.
REQ-010 SHALL have port i_psum_valid  input  1  qualifies i_psum0..2 this cycle.
REQ-011 SHALL have ports i_psum0/1/2  input  PS_BW each  per-channel signed partial sums.
REQ-012 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port o_acc_valid  output  1  one-cycle pulse marking new o_acc_bias0..2; drives downstream bound_en.
REQ-014 SHALL have ports o_acc_bias0/1/2  output  AB_BW each  registered signed results to bound/ReLU stage.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, BIAS, DONE.
REQ-016 IDLE: i_start=1 SHALL latch i_acc_len and biases, clear the three accumulators and beat counter, go to ACC next cycle.
REQ-017 ACC: each cycle with i_psum_valid=1 SHALL add sign-extended i_psumN to accumulator N and increment the beat counter; i_psum_valid=0 SHALL hold all state (gaps allowed, unbounded).
REQ-018 ACC: the valid beat with counter equal to latched length SHALL be accumulated and the FSM SHALL move to BIAS.
REQ-019 BIAS: SHALL compute accN + sign-extended biasN in AB_BW+1 bits, saturate to [-2^(AB_BW-1), 2^(AB_BW-1)-1], register into o_acc_biasN, move to DONE.
REQ-020 DONE: o_acc_valid SHALL be 1 for exactly this cycle; FSM returns to IDLE next cycle.
REQ-021 Latency SHALL be 2 cycles: last valid beat at edge t -> o_acc_valid high in cycle t+2.
REQ-022 Accumulation SHALL NOT overflow: 16 beats of PS_BW=17 fit AB_BW=21 exactly; saturation applies only at bias add.
REQ-023 i_start outside IDLE SHALL be ignored (no restart, no re-latch).
REQ-024 i_psum_valid outside ACC SHALL be ignored.
REQ-025 o_acc_bias0..2 SHALL hold last result until next DONE; i_bias/i_acc_len changes after acceptance SHALL have no effect on the current job.
REQ-026 Minimum job spacing SHALL be len+4 cycles (IDLE, ACC beats, BIAS, DONE).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, o_busy=0, o_acc_valid=0, o_acc_bias0..2=0, accumulators, counter and latched fields=0, with priority over all other inputs.
REQ-028 Reset mid-job SHALL abandon the job with no o_acc_valid pulse; i_start is accepted the first cycle after rst deasserts.

Structure
REQ-029 FSM state encoding and default widths (D_BW, PS_BW, AB_BW, LEN_BW) SHALL live in the shared accelerator package.
REQ-030 One sub-module acc_bias_lane (accumulator + bias add + saturate, one channel) SHALL be instantiated three times; FSM and counter stay in acc_bias_unit.

Verification
REQ-031 len=3, psum0..2={10,-5,100} x4 beats back-to-back, bias={1,-1,0} -> o_acc_bias={41,-21,400}, o_acc_valid exactly 2 cycles after 4th beat.
REQ-032 len=0, one beat psum0=-7, bias0=-128 -> o_acc_bias0=-135 after single beat; o_busy high 3 cycles.
REQ-033 len=15, psum0=65535 x16, bias0=127 -> o_acc_bias0=1048575 (positive saturation); psum1=-65536 x16, bias1=-1 -> -1048576 (negative saturation).
REQ-034 len=2 with valid gaps (1,0,0,1,0,1) plus i_start and new biases pulsed mid-ACC -> result uses 3 beats and original biases only; second i_start ignored.
REQ-035 rst asserted after 2 of 4 beats -> all outputs 0, no o_acc_valid; new job started next cycle completes with correct values.
